gate_sweep_checker: RTL

//  Exhaustive self-checking sweep engine for N-input logic gates; it does in hardware what our gate benches do by hand.
//  On start it drives every input pattern 0..2^N_IN-1 onto a gate under test, one pattern per cycle.
//  It compares the gate output against a built-in reference for the selected MODE.
//  It tallies mismatches and reports pass/fail, and it supports gates with 0..4 cycles of output latency.

---
 rtl/gate_sweep_pkg.sv | 47 ++++
 rtl/gate_sweep_checker_ref.sv | 17 +
 rtl/gate_sweep_checker.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared types and the gate reduction reference for the exhaustive gate sweep checker.
package gate_sweep_pkg;

    typedef enum logic [2:0] {
        MODE_AND  = 3'd0,
        MODE_OR   = 3'd1,
        MODE_XOR  = 3'd2,
        MODE_NAND = 3'd3,
        MODE_NOR  = 3'd4,
        MODE_XNOR = 3'd5
    } gate_mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } sweep_state_e;

    localparam logic [2:0] MODE_LAST = 3'd5;

    // vec is zero-padded to 8 bits; only the low n bits take part in the reduction.
    function automatic logic gate_ref(input gate_mode_e m, input logic [7:0] vec, input int n);
        logic a, o, x, r;
        a = 1'b1;
        o = 1'b0;
        x = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                a = a & vec[i];
                o = o | vec[i];
                x = x ^ vec[i];
            end
        end
        case (m)
            MODE_AND:  r = a;
            MODE_OR:   r = o;
            MODE_XOR:  r = x;
            MODE_NAND: r = ~a;
            MODE_NOR:  r = ~o;
            MODE_XNOR: r = ~x;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_sweep_checker_ref.sv
// Combinational N_IN-input reference gate used to produce the expected output per pattern.
module gate_ref_model
    import gate_sweep_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  gate_mode_e        mode,
    input  logic [N_IN-1:0]   vec,
    output logic              ref_out
);

    logic [7:0] vec8;

    assign vec8    = 8'(vec);
    assign ref_out = gate_ref(mode, vec8, N_IN);

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps every input pattern onto a gate under test and checks its output, tolerating
// 0..LAT cycles of gate latency via a delay line that carries pattern and expected value.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int LAT   = 0,
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        mode,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              first_err_vld,
    output logic [N_IN-1:0]   first_err_pat
);

    localparam int CW = N_IN + 1;
    localparam logic [CW-1:0] LAST_PAT   = CW'((1 << N_IN) - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'((LAT > 0) ? (LAT - 1) : 0);

    sweep_state_e      state, nstate;
    gate_mode_e        mode_q;
    logic [CW-1:0]     cnt;
    logic              accept, last_pat, mismatch;
    logic              ref0, vld0;
    logic              vld_tap, exp_tap;
    logic [N_IN-1:0]   pat_tap;

    gate_ref_model #(.N_IN(N_IN)) u_ref (
        .mode    (mode_q),
        .vec     (dut_in),
        .ref_out (ref0)
    );

    assign vld0     = (state == S_RUN);
    assign last_pat = (cnt == LAST_PAT);
    assign busy     = (state == S_RUN) || (state == S_DRAIN);
    assign done     = (state == S_DONE);

    // Pattern and expected value travel with the sweep so the compare lines up with dut_out.
    if (LAT > 0) begin : g_dly
        logic [LAT:1]            vld_pipe;
        logic [LAT:1]            exp_pipe;
        logic [LAT:1][N_IN-1:0]  pat_pipe;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_pipe <= '0;
                exp_pipe <= '0;
                pat_pipe <= '0;
            end else begin
                vld_pipe[1] <= vld0;
                exp_pipe[1] <= ref0;
                pat_pipe[1] <= dut_in;
                for (int i = 2; i <= LAT; i++) begin
                    vld_pipe[i] <= vld_pipe[i-1];
                    exp_pipe[i] <= exp_pipe[i-1];
                    pat_pipe[i] <= pat_pipe[i-1];
                end
            end
        end

        assign vld_tap = vld_pipe[LAT];
        assign exp_tap = exp_pipe[LAT];
        assign pat_tap = pat_pipe[LAT];
    end else begin : g_nodly
        assign vld_tap = vld0;
        assign exp_tap = ref0;
        assign pat_tap = dut_in;
    end

    assign mismatch = vld_tap && (dut_out != exp_tap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        accept = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && (mode <= MODE_LAST)) begin
                    accept = 1'b1;
                    nstate = S_RUN;
                end
            end
            S_RUN:   if (last_pat) nstate = (LAT > 0) ? S_DRAIN : S_DONE;
            S_DRAIN: if (cnt == DRAIN_LAST) nstate = S_DONE;
            S_DONE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= MODE_AND;
            cnt           <= '0;
            dut_in        <= '0;
            err_cnt       <= '0;
            pass          <= 1'b0;
            first_err_vld <= 1'b0;
            first_err_pat <= '0;
        end else if (accept) begin
            mode_q        <= gate_mode_e'(mode);
            cnt           <= '0;
            dut_in        <= '0;
            err_cnt       <= '0;
            pass          <= 1'b0;
            first_err_vld <= 1'b0;
            first_err_pat <= '0;
        end else begin
            // cnt walks the patterns in RUN, then is reused to time the drain.
            case (state)
                S_RUN: begin
                    if (last_pat) begin
                        cnt <= '0;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        dut_in <= dut_in + 1'b1;
                    end
                end
                S_DRAIN: cnt <= cnt + 1'b1;
                default: ;
            endcase
            // The final compare lands on the same edge that enters DONE.
            if (nstate == S_DONE) begin
                dut_in <= '0;
                pass   <= ~(first_err_vld | mismatch);
            end
            if (mismatch) begin
                if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
                if (!first_err_vld) begin
                    first_err_vld <= 1'b1;
                    first_err_pat <= pat_tap;
                end
            end
        end
    end

endmodule
